lcd_line_formatter: RTL and testbench



---
 rtl/lcd_line_formatter_if.sv | 32 +++
 rtl/lcd_line_formatter.sv | 134 +++++++++++++
 tb/tb_lcd_line_formatter.sv | 312 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/lcd_line_formatter_if.sv
// Request/response bundle between a line producer and the LCD line formatter.
// The master side issues start/value/label; the slave side returns the
// assembled display line plus go/busy/done status.
interface lcd_line_formatter_if;
    logic         start;
    logic [15:0]  value;
    logic [63:0]  label;
    logic [127:0] display;
    logic         go;
    logic         busy;
    logic         done;

    modport master (
        output start,
        output value,
        output label,
        input  display,
        input  go,
        input  busy,
        input  done
    );

    modport slave (
        input  start,
        input  value,
        input  label,
        output display,
        output go,
        output busy,
        output done
    );
endinterface

// File: rtl/lcd_line_formatter.sv
// LCD line formatter: converts a 16-bit value to five decimal digits using a
// sequential double-dabble, builds "LABEL   :ddddd  " and holds go high long
// enough for a refresh-gated LCD controller to observe it.
module lcd_line_formatter #(
    parameter int unsigned LEADING_ZEROS = 0,   // 0: blank leading zeros, 1: show all digits
    parameter int unsigned GO_HOLD       = 255  // go high time in cycles, 1..255
) (
    input logic                 Clk,
    input logic                 Rst,
    lcd_line_formatter_if.slave lcd
);
    localparam logic [127:0] BlankLine = {16{8'h20}};

    typedef enum logic [2:0] {
        StIdle,
        StConv,
        StFmt,
        StGo,
        StFin
    } state_t;

    state_t       state;
    logic [15:0]  shift;
    logic [19:0]  bcd;
    logic [19:0]  bcd_adj;
    logic [3:0]   bit_cnt;
    logic [7:0]   hold_cnt;
    logic [63:0]  label_lat;
    logic [127:0] display_reg;
    logic         go_reg;
    logic         busy_reg;
    logic         done_reg;

    logic [127:0] line;
    logic         lead;
    logic [3:0]   digit;

    // Double-dabble add-3 correction applied to every BCD nibble before the shift.
    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < 5; i++) begin
            if (bcd[4*i +: 4] >= 4'd5) begin
                bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
            end
        end
    end

    // Assemble the display line from the latched label and finished BCD digits.
    always_comb begin
        line          = BlankLine;
        line[127:64]  = label_lat;
        line[63:56]   = 8'h3A;
        lead          = (LEADING_ZEROS == 0);
        digit         = 4'd0;
        // Digits d4..d0 occupy chars 10..14; d0 is never blanked.
        for (int i = 4; i >= 0; i--) begin
            digit = bcd[4*i +: 4];
            if (lead && (i != 0) && (digit == 4'd0)) begin
                line[23 + 8*i -: 8] = 8'h20;
            end else begin
                line[23 + 8*i -: 8] = {4'h3, digit};
                lead                = 1'b0;
            end
        end
    end

    // Control FSM with registered go/busy/done and display outputs.
    always_ff @(posedge Clk) begin
        if (Rst) begin
            state       <= StIdle;
            shift       <= 16'd0;
            bcd         <= 20'd0;
            bit_cnt     <= 4'd0;
            hold_cnt    <= 8'd0;
            label_lat   <= 64'd0;
            display_reg <= BlankLine;
            go_reg      <= 1'b0;
            busy_reg    <= 1'b0;
            done_reg    <= 1'b0;
        end else begin
            case (state)
                StIdle: begin
                    done_reg <= 1'b0;
                    busy_reg <= 1'b0;
                    if (lcd.start) begin
                        shift     <= lcd.value;
                        label_lat <= lcd.label;
                        bcd       <= 20'd0;
                        bit_cnt   <= 4'd0;
                        busy_reg  <= 1'b1;
                        state     <= StConv;
                    end
                end
                StConv: begin
                    // One bit per cycle, MSB first, through the corrected BCD register.
                    {bcd, shift} <= {bcd_adj, shift} << 1;
                    bit_cnt      <= bit_cnt + 4'd1;
                    if (bit_cnt == 4'd15) begin
                        state <= StFmt;
                    end
                end
                StFmt: begin
                    // Display settles one cycle before go rises.
                    display_reg <= line;
                    hold_cnt    <= 8'd0;
                    state       <= StGo;
                end
                StGo: begin
                    if (hold_cnt == 8'(GO_HOLD)) begin
                        go_reg   <= 1'b0;
                        done_reg <= 1'b1;
                        state    <= StFin;
                    end else begin
                        go_reg   <= 1'b1;
                        hold_cnt <= hold_cnt + 8'd1;
                    end
                end
                StFin: begin
                    done_reg <= 1'b0;
                    busy_reg <= 1'b0;
                    state    <= StIdle;
                end
                default: begin
                    state <= StIdle;
                end
            endcase
        end
    end

    assign lcd.display = display_reg;
    assign lcd.go      = go_reg;
    assign lcd.busy    = busy_reg;
    assign lcd.done    = done_reg;
endmodule

// File: tb/tb_lcd_line_formatter.sv
// Bench for lcd_line_formatter: three instances with different parameter sets
// share one stimulus stream; a timeline model predicts every output each cycle.
module tb_lcd_line_formatter;
    localparam logic [127:0] Blank = {16{8'h20}};

    logic         Clk = 1'b0;
    logic         rst;
    logic         start;
    logic [15:0]  value;
    logic [63:0]  label;

    always #5 Clk = ~Clk;

    lcd_line_formatter_if if_a ();
    lcd_line_formatter_if if_b ();
    lcd_line_formatter_if if_c ();

    assign if_a.start = start;
    assign if_a.value = value;
    assign if_a.label = label;
    assign if_b.start = start;
    assign if_b.value = value;
    assign if_b.label = label;
    assign if_c.start = start;
    assign if_c.value = value;
    assign if_c.label = label;

    lcd_line_formatter #(.LEADING_ZEROS(0), .GO_HOLD(255)) dut_a (
        .Clk (Clk),
        .Rst (rst),
        .lcd (if_a)
    );
    lcd_line_formatter #(.LEADING_ZEROS(1), .GO_HOLD(3)) dut_b (
        .Clk (Clk),
        .Rst (rst),
        .lcd (if_b)
    );
    lcd_line_formatter #(.LEADING_ZEROS(0), .GO_HOLD(1)) dut_c (
        .Clk (Clk),
        .Rst (rst),
        .lcd (if_c)
    );

    logic [127:0] disp_obs [3];
    logic         go_obs   [3];
    logic         busy_obs [3];
    logic         done_obs [3];

    assign disp_obs[0] = if_a.display;
    assign disp_obs[1] = if_b.display;
    assign disp_obs[2] = if_c.display;
    assign go_obs[0]   = if_a.go;
    assign go_obs[1]   = if_b.go;
    assign go_obs[2]   = if_c.go;
    assign busy_obs[0] = if_a.busy;
    assign busy_obs[1] = if_b.busy;
    assign busy_obs[2] = if_c.busy;
    assign done_obs[0] = if_a.done;
    assign done_obs[1] = if_b.done;
    assign done_obs[2] = if_c.done;

    // Reference model state: per instance, active flag and acceptance edge.
    bit           m_active [3];
    int           m_acc    [3];
    logic [127:0] m_disp   [3];
    logic [127:0] m_pend   [3];
    int           edge_idx;
    int           go_cnt   [3];
    int           busy_cnt [3];
    int           done_cnt [3];

    int n_checks;
    int n_fail;

    function automatic int hold_of(input int d);
        case (d)
            0:       return 255;
            1:       return 3;
            default: return 1;
        endcase
    endfunction

    function automatic bit lz_of(input int d);
        return (d == 1);
    endfunction

    task automatic check_eq(input string tag, input logic [127:0] obs, input logic [127:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", tag, obs, exp);
        end
    endtask

    // Expected line from plain decimal arithmetic.
    function automatic logic [127:0] fmt_line(input logic [63:0] l, input logic [15:0] v,
                                              input bit show_all);
        logic [127:0] s;
        int           dg [5];
        int           n;
        bit           blank;
        n = int'(v);
        for (int i = 0; i < 5; i++) begin
            dg[i] = n % 10;
            n     = n / 10;
        end
        s          = Blank;
        s[127:64]  = l;
        s[63:56]   = 8'h3A;
        blank      = !show_all;
        for (int i = 4; i >= 0; i--) begin
            if (blank && i != 0 && dg[i] == 0) begin
                s[127 - 8*(13 - i) -: 8] = 8'h20;
            end else begin
                s[127 - 8*(13 - i) -: 8] = 8'(8'h30 + dg[i]);
                blank = 1'b0;
            end
        end
        return s;
    endfunction

    function automatic logic [63:0] rand_label();
        logic [63:0] l;
        for (int i = 0; i < 8; i++) begin
            l[8*i +: 8] = 8'(8'h20 + $urandom_range(0, 94));
        end
        return l;
    endfunction

    // Advance the model by one clock edge using the inputs the bench is driving.
    task automatic model_edge();
        edge_idx++;
        for (int d = 0; d < 3; d++) begin
            if (rst) begin
                m_active[d] = 1'b0;
                m_disp[d]   = Blank;
            end else if (m_active[d]) begin
                if (edge_idx - m_acc[d] == 17) m_disp[d] = m_pend[d];
                if (edge_idx - m_acc[d] == 19 + hold_of(d)) m_active[d] = 1'b0;
            end else if (start) begin
                m_active[d] = 1'b1;
                m_acc[d]    = edge_idx;
                m_pend[d]   = fmt_line(label, value, lz_of(d));
            end
        end
    endtask

    task automatic check_outputs();
        for (int d = 0; d < 3; d++) begin
            int k;
            bit e_go;
            bit e_done;
            k      = edge_idx - m_acc[d];
            e_go   = m_active[d] && k >= 18 && k <= 17 + hold_of(d);
            e_done = m_active[d] && k == 18 + hold_of(d);
            check_eq($sformatf("busy%0d@%0d", d, edge_idx), busy_obs[d], m_active[d]);
            check_eq($sformatf("go%0d@%0d", d, edge_idx), go_obs[d], e_go);
            check_eq($sformatf("done%0d@%0d", d, edge_idx), done_obs[d], e_done);
            check_eq($sformatf("disp%0d@%0d", d, edge_idx), disp_obs[d], m_disp[d]);
            if (go_obs[d] === 1'b1) go_cnt[d]++;
            if (busy_obs[d] === 1'b1) busy_cnt[d]++;
            if (done_obs[d] === 1'b1) done_cnt[d]++;
        end
    endtask

    task automatic tick();
        @(posedge Clk);
        model_edge();
        @(negedge Clk);
        check_outputs();
    endtask

    task automatic clear_counts();
        for (int d = 0; d < 3; d++) begin
            go_cnt[d]   = 0;
            busy_cnt[d] = 0;
            done_cnt[d] = 0;
        end
    endtask

    task automatic request(input logic [15:0] v, input logic [63:0] l);
        value = v;
        label = l;
        start = 1'b1;
        tick();
        start = 1'b0;
        value = 16'($urandom);
        label = rand_label();
    endtask

    // Run until every instance is idle; optionally spray ignored starts at dut_a.
    task automatic wait_idle(input bit noisy);
        int n;
        n = 0;
        while ((m_active[0] || m_active[1] || m_active[2]) && n < 400) begin
            start = noisy && m_active[0] && ($urandom_range(0, 3) == 0);
            value = 16'($urandom);
            label = rand_label();
            tick();
            n++;
        end
        start = 1'b0;
        if (n >= 400) begin
            check_eq("idle_timeout", busy_obs[0] | busy_obs[1] | busy_obs[2], 1'b0);
        end
    endtask

    initial begin
        logic [15:0] v;
        n_checks = 0;
        n_fail   = 0;
        edge_idx = 0;
        for (int d = 0; d < 3; d++) begin
            m_active[d] = 1'b0;
            m_acc[d]    = 0;
            m_disp[d]   = Blank;
            m_pend[d]   = Blank;
        end
        clear_counts();
        rst   = 1'b1;
        start = 1'b0;
        value = 16'd0;
        label = 64'd0;
        repeat (3) tick();
        rst = 1'b0;
        tick();

        // Zero with blanking, full go window on dut_a.
        clear_counts();
        request(16'd0, "TEMP    ");
        wait_idle(1'b0);
        check_eq("line_zero", disp_obs[0], "TEMP    :    0  ");
        check_eq("go_len_a", go_cnt[0], 255);
        check_eq("done_cnt_a", done_cnt[0], 1);

        request(16'd65535, "COUNT   ");
        wait_idle(1'b0);
        check_eq("line_max", disp_obs[0], "COUNT   :65535  ");

        request(16'd1234, "LZ      ");
        wait_idle(1'b0);
        check_eq("line_1234_blank", disp_obs[0], "LZ      : 1234  ");
        check_eq("line_1234_zeros", disp_obs[1], "LZ      :01234  ");

        // Starts while busy must be dropped.
        clear_counts();
        request(16'd7, "SEVEN   ");
        wait_idle(1'b1);
        check_eq("line_busy_ignore", disp_obs[0], "SEVEN   :    7  ");
        check_eq("done_once", done_cnt[0], 1);

        // Reset mid-conversion after a completed line.
        request(16'd5555, "ABORT   ");
        repeat (7) tick();
        rst = 1'b1;
        tick();
        rst = 1'b0;
        check_eq("rst_busy", busy_obs[0], 1'b0);
        check_eq("rst_go", go_obs[0], 1'b0);
        check_eq("rst_disp", disp_obs[0], Blank);
        request(16'd42, "LBL     ");
        wait_idle(1'b0);
        check_eq("line_42", disp_obs[0], "LBL     :   42  ");

        // Minimum go hold on dut_c.
        clear_counts();
        request(16'd100, "HUNDRED ");
        wait_idle(1'b0);
        check_eq("line_100", disp_obs[2], "HUNDRED :  100  ");
        check_eq("go_len_c", go_cnt[2], 1);
        check_eq("busy_len_c", busy_cnt[2], 20);

        // Start held high: back-to-back acceptance.
        start = 1'b1;
        for (int i = 0; i < 700; i++) begin
            value = 16'($urandom);
            label = rand_label();
            tick();
        end
        start = 1'b0;
        wait_idle(1'b0);

        // Randomized requests with occasional mid-flight resets.
        for (int it = 0; it < 40; it++) begin
            case ($urandom_range(0, 3))
                0:       v = 16'd0;
                1:       v = 16'd65535;
                2:       v = 16'($urandom_range(0, 99));
                default: v = 16'($urandom);
            endcase
            request(v, rand_label());
            if ($urandom_range(0, 4) == 0) begin
                int n;
                n = $urandom_range(1, 280);
                for (int i = 0; i < n; i++) begin
                    start = ($urandom_range(0, 3) == 0);
                    value = 16'($urandom);
                    tick();
                end
                start = 1'b0;
                rst   = 1'b1;
                tick();
                rst   = 1'b0;
            end
            wait_idle($urandom_range(0, 1) == 1);
        end

        repeat (2) tick();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
